// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared opcodes, states, grant kinds and frame field positions for the SPI frame scheduler
package spi_frame_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RSVD = 2'b01, OP_WRITE = 2'b10, OP_READ = 2'b11} op_e;
  typedef enum logic {ST_IDLE, ST_LOADED} state_e;
  typedef enum logic [1:0] {G_IDLE, G_SRC, G_RB} grant_e;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int ADDR_HI = 29;
  localparam int ADDR_LO = 24;
  localparam int ERR_BIT = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;
  function automatic logic [31:0] rb_frame(input logic [5:0] addr, input logic err, input logic [15:0] data);
    return {OP_READ, addr, 7'd0, err, data};
  endfunction
endpackage

// File: rtl/spi_frame_scheduler_rr_arbiter.sv
// rr_arbiter: first requester at or above the pointer, wrapping modulo N
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);
  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % N);
  endfunction
  // scanning downward lets the closest requester to the pointer win last
  always_comb begin
    grant_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[wrap(int'(ptr_i) + k)]) begin
        grant_o = wrap(int'(ptr_i) + k);
        any_o = 1'b1;
      end
  end
endmodule

// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: picks each outgoing SPI frame and decodes received frames into config writes/readbacks
module spi_frame_scheduler
  import spi_frame_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter int          N_REG      = 8,
  parameter logic [31:0] IDLE_FRAME = 32'h4FDD_E000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_req,
  input  logic [31:0]           spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [31:0]           data_frame,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [32*N_SRC-1:0]   src_data,
  output logic [N_SRC-1:0]      src_ack,
  output logic [16*N_REG-1:0]   cfg_regs,
  output logic [N_REG-1:0]      cfg_wr,
  output logic                  err_pulse
);
  localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic                req_q;
  state_e              state_q;
  grant_e              kind_q;
  logic [SW-1:0]       gnt_idx_q, rr_q, rr_d, grant;
  logic                rb_pend_q, rb_pend_d;
  logic [5:0]          rb_addr_q, rb_addr_d;
  logic [31:0]         frame_q, frame_d;
  logic [N_SRC-1:0]    ack_q, ack_d;
  logic [16*N_REG-1:0] regs_q, regs_d;
  logic [N_REG-1:0]    wr_q, wr_d;
  logic                err_q, err_d;
  logic                request, done, any, addr_ok, rb_ok, wr_hit, rd_cmd;
  logic [15:0]         rb_val;
  op_e                 op;
  logic [5:0]          rx_addr;
  logic [15:0]         rx_data;
  logic                unused_rx;
  assign unused_rx = ^spi_rx_data[ERR_BIT+7:ERR_BIT];
  assign op      = op_e'(spi_rx_data[OP_HI:OP_LO]);
  assign rx_addr = spi_rx_data[ADDR_HI:ADDR_LO];
  assign rx_data = spi_rx_data[DATA_HI:DATA_LO];
  assign request = spi_req & ~req_q;
  assign done    = spi_rx_valid && state_q == ST_LOADED;
  assign addr_ok = int'(rx_addr) < N_REG;
  assign wr_hit  = spi_rx_valid && op == OP_WRITE && addr_ok;
  assign rd_cmd  = spi_rx_valid && op == OP_READ;
  assign err_d   = spi_rx_valid && (op == OP_RSVD || (op == OP_WRITE && !addr_ok));
  assign wr_d    = wr_hit ? N_REG'(1) << rx_addr : '0;
  assign ack_d   = (done && kind_q == G_SRC) ? src_valid & (N_SRC'(1) << gnt_idx_q) : '0;
  assign rr_d    = (done && kind_q == G_SRC) ? (gnt_idx_q == SW'(N_SRC - 1) ? '0 : gnt_idx_q + 1'b1) : rr_q;
  // a READ arriving with the readback's own completion re-arms the request
  assign rb_pend_d = rd_cmd | (rb_pend_q & ~(done && kind_q == G_RB));
  assign rb_addr_d = rd_cmd ? rx_addr : rb_addr_q;
  assign rb_ok     = int'(rb_addr_d) < N_REG;
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[16*int'(rx_addr) +: 16] = rx_data;
  end
  assign rb_val  = rb_ok ? regs_d[16*int'(rb_addr_d) +: 16] : '0;
  assign frame_d = rb_pend_d ? rb_frame(rb_addr_d, ~rb_ok, rb_val) : any ? src_data[32*int'(grant) +: 32] : IDLE_FRAME;
  rr_arbiter #(.N(N_SRC)) u_arb (
    .req_i   (src_valid),
    .ptr_i   (rr_d),
    .grant_o (grant),
    .any_o   (any)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      state_q   <= ST_IDLE;
      kind_q    <= G_IDLE;
      gnt_idx_q <= '0;
      rr_q      <= '0;
      rb_pend_q <= 1'b0;
      rb_addr_q <= '0;
      frame_q   <= IDLE_FRAME;
      ack_q     <= '0;
      regs_q    <= '0;
      wr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      req_q     <= spi_req;
      rr_q      <= rr_d;
      rb_pend_q <= rb_pend_d;
      rb_addr_q <= rb_addr_d;
      ack_q     <= ack_d;
      regs_q    <= regs_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      if (request) begin
        state_q   <= ST_LOADED;
        kind_q    <= rb_pend_d ? G_RB : any ? G_SRC : G_IDLE;
        gnt_idx_q <= grant;
        frame_q   <= frame_d;
      end else if (done) begin
        state_q <= ST_IDLE;
      end
    end
  end
  assign data_frame = frame_q;
  assign src_ack    = ack_q;
  assign cfg_regs   = regs_q;
  assign cfg_wr     = wr_q;
  assign err_pulse  = err_q;
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// tb_spi_frame_scheduler: directed plus randomized checks of the frame scheduler against a behavioural model
module tb_spi_frame_scheduler;
  localparam int N_SRC = 4;
  localparam int N_REG = 8;
  localparam logic [31:0] IDLE = 32'h4FDD_E000;
  logic clk = 1'b0, reset = 1'b1, spi_req = 1'b0, spi_rx_valid = 1'b0;
  logic [31:0] spi_rx_data = '0;
  logic [N_SRC-1:0] src_valid = '0;
  logic [32*N_SRC-1:0] src_data = '0;
  logic [31:0] data_frame;
  logic [N_SRC-1:0] src_ack;
  logic [16*N_REG-1:0] cfg_regs;
  logic [N_REG-1:0] cfg_wr;
  logic err_pulse;
  int checks = 0, errors = 0;
  logic [15:0] m_regs [N_REG];
  int m_rr, m_rb_addr, m_kind;
  bit m_rb, m_loaded, m_err, m_prev, reload_en;
  logic [31:0] m_frame;
  logic [N_SRC-1:0] m_ack;
  logic [N_REG-1:0] m_wr;
  always #5 clk = ~clk;
  spi_frame_scheduler #(.N_SRC(N_SRC), .N_REG(N_REG), .IDLE_FRAME(IDLE)) dut (
    .clk(clk), .reset(reset), .spi_req(spi_req), .spi_rx_data(spi_rx_data),
    .spi_rx_valid(spi_rx_valid), .data_frame(data_frame), .src_valid(src_valid),
    .src_data(src_data), .src_ack(src_ack), .cfg_regs(cfg_regs), .cfg_wr(cfg_wr),
    .err_pulse(err_pulse)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] m_bank();
    logic [127:0] b = '0;
    for (int i = 0; i < N_REG; i++) b[16*i +: 16] = m_regs[i];
    return b;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < N_REG; i++) m_regs[i] = '0;
    m_rr = 0; m_rb = 0; m_rb_addr = 0; m_loaded = 0; m_kind = -1; m_prev = 0;
    m_frame = IDLE; m_ack = '0; m_wr = '0; m_err = 0;
  endtask
  task automatic check_outputs();
    check("data_frame", data_frame, m_frame);
    check("src_ack", src_ack, m_ack);
    check("cfg_wr", cfg_wr, m_wr);
    check("err_pulse", err_pulse, m_err);
    check("cfg_regs", cfg_regs, m_bank());
  endtask
  // one clock: model reacts to the inputs in spec order (completion, decode, selection)
  task automatic cyc(input bit req, input bit rxv, input logic [31:0] rx);
    int op, a, i;
    bit request;
    spi_req = req; spi_rx_valid = rxv; spi_rx_data = rx;
    request = req && !m_prev;
    m_prev = req;
    m_ack = '0; m_wr = '0; m_err = 0;
    if (rxv) begin
      if (m_loaded) begin
        if (m_kind >= 0) begin
          if (src_valid[m_kind]) m_ack[m_kind] = 1'b1;
          m_rr = (m_kind + 1) % N_SRC;
        end else if (m_kind == -2) m_rb = 0;
        m_loaded = 0;
      end
      op = int'(rx[31:30]);
      a = int'(rx[29:24]);
      if (op == 2) begin
        if (a < N_REG) begin m_regs[a] = rx[15:0]; m_wr[a] = 1'b1; end
        else m_err = 1;
      end else if (op == 3) begin
        m_rb = 1; m_rb_addr = a;
      end else if (op == 1) m_err = 1;
    end
    if (request) begin
      m_loaded = 1; m_kind = -1; m_frame = IDLE;
      if (m_rb) begin
        m_kind = -2;
        m_frame = {2'b11, 6'(m_rb_addr), 7'd0, m_rb_addr >= N_REG, (m_rb_addr < N_REG) ? m_regs[m_rb_addr] : 16'h0};
      end else
        for (int k = 0; k < N_SRC; k++) begin
          i = (m_rr + k) % N_SRC;
          if (src_valid[i]) begin m_kind = i; m_frame = src_data[32*i +: 32]; break; end
        end
    end
    @(posedge clk);
    #1;
    check_outputs();
    for (int j = 0; j < N_SRC; j++)
      if (m_ack[j]) begin
        if (reload_en && $urandom_range(1) == 1) src_data[32*j +: 32] = $urandom;
        else src_valid[j] = 1'b0;
      end
  endtask
  task automatic do_frame(input logic [31:0] rx, input bit abort);
    repeat (3) cyc(1, 0, '0);
    repeat (2) cyc(0, 0, '0);
    if (!abort) cyc(0, 1, rx);
    cyc(0, 0, '0);
  endtask
  initial begin
    bit r = 0;
    logic [31:0] rx;
    m_reset();
    reload_en = 0;
    for (int i = 0; i < N_SRC; i++) src_data[32*i +: 32] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
    do_frame(32'h0000_0000, 0);
    check("idle_frame", data_frame, IDLE);
    src_valid = 4'b1010;
    do_frame('0, 0);
    check("first_src1", data_frame, src_data[63:32]);
    do_frame('0, 0);
    check("then_src3", data_frame, src_data[127:96]);
    src_valid = 4'b0011;
    do_frame('0, 0);
    check("rr_wrapped_src0", data_frame, src_data[31:0]);
    src_valid = '0;
    do_frame(32'h8300_ABCD, 0);
    check("write_addr3", cfg_regs[63:48], 16'hABCD);
    do_frame(32'h8900_1234, 0);
    check("bad_write_bank", cfg_regs, 128'h0000_0000_0000_0000_0000_0000_ABCD_0000_0000_0000);
    do_frame(32'hC300_0000, 0);
    src_valid = 4'b0001;
    do_frame('0, 0);
    check("readback_frame", data_frame, 32'hC300_ABCD);
    do_frame('0, 0);
    check("src0_after_rb", data_frame, src_data[31:0]);
    src_valid = 4'b0100;
    do_frame('0, 1);
    check("abort_grant", data_frame, src_data[95:64]);
    do_frame('0, 0);
    check("regrant_src2", data_frame, src_data[95:64]);
    do_frame(32'hC500_0000, 0);
    cyc(1, 0, '0);
    check("rb_loaded", data_frame, 32'hC500_0000);
    spi_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
    src_valid = '0;
    do_frame('0, 0);
    check("idle_after_reset", data_frame, IDLE);
    reload_en = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < N_SRC; j++)
        if (!src_valid[j] && $urandom_range(7) == 0) begin
          src_valid[j] = 1'b1;
          src_data[32*j +: 32] = $urandom;
        end
      if ($urandom_range(3) == 0) r = !r;
      rx = {2'($urandom_range(3)), 6'($urandom_range(11)), 8'($urandom), 16'($urandom)};
      cyc(r, $urandom_range(5) == 0, rx);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
